// File: rtl/hevc_subpel_row_sched.sv
// Row scheduler for HEVC luma sub-pel interpolation: builds the 8-tap window, issues
// samples to the shared FIR bus, and buffers the selected results in a credit-guarded skid FIFO.
module hevc_subpel_row_sched #(
    parameter int FIR_LAT = 1,
    parameter int MAX_LEN = 64
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        start,
    input  logic [1:0]  frac,
    input  logic [6:0]  row_len,
    output logic        busy,
    output logic        err,
    output logic        done,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [63:0] fir_pixels,
    input  logic [7:0]  fir_a_sub,
    input  logic [7:0]  fir_b_sub,
    input  logic [7:0]  fir_c_sub,
    output logic [7:0]  out_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);
    localparam int DEPTH = FIR_LAT + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DRAIN} state_t;

    state_t         state_r, state_nxt;
    logic [1:0]     frac_r;
    logic [6:0]     len_r;
    logic [2:0]     fill_cnt_r;
    logic [6:0]     issue_cnt_r;
    logic [63:0]    window_r;
    logic           err_r, done_r;
    logic [FIR_LAT:0] vld_pipe_r, last_pipe_r;
    logic [7:0]     byp_r [FIR_LAT];
    logic [8:0]     fifo_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r, count_nxt;

    logic           accept_s, issue_s, last_s, start_ok_s, start_bad_s, done_nxt;
    logic           push_s, pop_s, credit_ok_s, drain_pipe_s;
    logic [CW:0]    inflight_s;
    logic [7:0]     push_data_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign busy       = (state_r != ST_IDLE);
    assign err        = err_r;
    assign done       = done_r;
    assign accept_s   = pix_valid & pix_ready;
    assign fir_pixels = (frac_r == 2'd3) ? {8'h00, window_r[63:8]} : window_r;
    assign push_s     = vld_pipe_r[FIR_LAT];
    assign out_valid  = (count_r != {CW{1'b0}});
    assign pop_s      = out_valid & out_ready;
    assign out_pix    = fifo_r[rd_ptr_r][7:0];
    assign out_last   = fifo_r[rd_ptr_r][8] & out_valid;
    assign last_s     = issue_s & (issue_cnt_r == len_r - 7'd1);
    assign credit_ok_s = ((inflight_s + {1'b0, count_r}) < DEPTH_W);

    // In-flight accounting: credits held by the pipe, and whether it still holds work after this edge
    always_comb begin
        inflight_s   = {(CW + 1){1'b0}};
        drain_pipe_s = 1'b0;
        for (int i = 0; i <= FIR_LAT; i++) begin
            inflight_s = inflight_s + {{CW{1'b0}}, vld_pipe_r[i]};
        end
        for (int i = 0; i < FIR_LAT; i++) begin
            drain_pipe_s = drain_pipe_s | vld_pipe_r[i];
        end
    end

    // FIFO occupancy after this edge
    always_comb begin
        count_nxt = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt = count_r + CW'(1);
            2'b01:   count_nxt = count_r - CW'(1);
            default: count_nxt = count_r;
        endcase
    end

    // Result source for the row's fractional position
    always_comb begin
        push_data_s = 8'd0;
        case (frac_r)
            2'd0:    push_data_s = byp_r[FIR_LAT-1];
            2'd1:    push_data_s = fir_a_sub;
            2'd2:    push_data_s = fir_b_sub;
            2'd3:    push_data_s = fir_c_sub;
            default: push_data_s = 8'd0;
        endcase
    end

    // Row FSM next-state and handshake decode
    always_comb begin
        state_nxt   = state_r;
        pix_ready   = 1'b0;
        issue_s     = 1'b0;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        done_nxt    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((row_len != 7'd0) && (row_len <= MAX_LEN_W)) begin
                        start_ok_s = 1'b1;
                        state_nxt  = ST_FILL;
                    end else begin
                        start_bad_s = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                pix_ready = 1'b1;
                if (accept_s && (fill_cnt_r == 3'd6)) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            ST_RUN: begin
                pix_ready = credit_ok_s;
                issue_s   = accept_s;
                if (last_s) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // done lands in the cycle right after the final pop
                if ((count_nxt == {CW{1'b0}}) && !drain_pipe_s) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state, latched row parameters and sliding window
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_r     <= ST_IDLE;
            frac_r      <= 2'd0;
            len_r       <= 7'd0;
            fill_cnt_r  <= 3'd0;
            issue_cnt_r <= 7'd0;
            window_r    <= 64'd0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nxt;
            err_r   <= start_bad_s;
            done_r  <= done_nxt;
            if (start_ok_s) begin
                frac_r      <= frac;
                len_r       <= row_len;
                fill_cnt_r  <= 3'd0;
                issue_cnt_r <= 7'd0;
            end else begin
                if (accept_s && (state_r == ST_FILL)) fill_cnt_r <= fill_cnt_r + 3'd1;
                if (issue_s) issue_cnt_r <= issue_cnt_r + 7'd1;
            end
            if (accept_s) window_r <= {pix_in, window_r[63:8]};
        end
    end

    // Issue tracking and integer-pel bypass, matched to the filter latency
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            vld_pipe_r  <= '0;
            last_pipe_r <= '0;
            for (int i = 0; i < FIR_LAT; i++) byp_r[i] <= 8'd0;
        end else begin
            vld_pipe_r[0]  <= issue_s;
            last_pipe_r[0] <= last_s;
            for (int i = 1; i <= FIR_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
            byp_r[0] <= window_r[31:24];
            for (int i = 1; i < FIR_LAT; i++) byp_r[i] <= byp_r[i-1];
        end
    end

    // Skid FIFO storage and pointers
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) fifo_r[i] <= 9'd0;
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            count_r <= count_nxt;
            if (push_s) begin
                fifo_r[wr_ptr_r] <= {last_pipe_r[FIR_LAT], push_data_s};
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
    end
endmodule

// File: tb/tb_hevc_subpel_row_sched.sv
// Directed bench for hevc_subpel_row_sched: external FIR models plus an output scoreboard
// whose expectations come straight from the pixel stream and the HEVC luma tap tables.
module tb_hevc_subpel_row_sched;
    logic        clock;
    logic        reset_L;
    logic        start;
    logic [1:0]  frac;
    logic [6:0]  row_len;
    logic        busy, err, done;
    logic [7:0]  pix_in;
    logic        pix_valid, pix_ready;
    logic [63:0] fir_pixels;
    logic [7:0]  fir_a_sub = 8'd0;
    logic [7:0]  fir_b_sub = 8'd0;
    logic [7:0]  fir_c_sub = 8'd0;
    logic [7:0]  out_pix;
    logic        out_valid, out_ready, out_last;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pix_idx = 0;
    int done_cnt = 0;
    int last_pop_cyc = -10;
    int stall_cnt = 0;
    logic [7:0] pix_q[$];
    logic [8:0] exp_q[$];

    hevc_subpel_row_sched #(.FIR_LAT(1), .MAX_LEN(64)) dut (
        .clock(clock), .reset_L(reset_L), .start(start), .frac(frac), .row_len(row_len),
        .busy(busy), .err(err), .done(done), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .fir_pixels(fir_pixels), .fir_a_sub(fir_a_sub),
        .fir_b_sub(fir_b_sub), .fir_c_sub(fir_c_sub), .out_pix(out_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // HEVC luma taps applied to p-3..p+4
    function automatic int coef(input int f, input int j);
        int a[8];
        case (f)
            1:       a = '{-1, 4, -10, 58, 17, -5, 1, 0};
            2:       a = '{-1, 4, -11, 40, 40, -11, 4, -1};
            3:       a = '{0, 1, -5, 17, 58, -10, 4, -1};
            default: a = '{0, 0, 0, 64, 0, 0, 0, 0};
        endcase
        return a[j];
    endfunction

    function automatic logic [7:0] clip(input int s);
        int v;
        v = (s + 32) >>> 6;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // Filter model as seen on the bus; FIR_C gets taps p-2..p+4 in bytes 0..6
    function automatic logic [7:0] fir_model(input int f, input logic [63:0] w);
        int s;
        s = 0;
        for (int j = 0; j < 8; j++) begin
            if (f == 3) s += ((j < 7) ? coef(3, j + 1) : 0) * int'(w[8*j +: 8]);
            else        s += coef(f, j) * int'(w[8*j +: 8]);
        end
        return clip(s);
    endfunction

    function automatic logic [7:0] exp_sample(input int f, input int k);
        int s;
        if (f == 0) return pix_q[k + 3];
        s = 0;
        for (int j = 0; j < 8; j++) s += coef(f, j) * int'(pix_q[k + j]);
        return clip(s);
    endfunction

    always @(posedge clock) begin
        fir_a_sub <= fir_model(1, fir_pixels);
        fir_b_sub <= fir_model(2, fir_pixels);
        fir_c_sub <= fir_model(3, fir_pixels);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_pix();
        if (pix_idx < pix_q.size()) begin
            pix_valid = 1'b1;
            pix_in    = pix_q[pix_idx];
        end else begin
            pix_valid = 1'b0;
            pix_in    = 8'd0;
        end
    endtask

    // One clock: sample at negedge, then update drivers just after posedge
    task automatic step();
        logic adv;
        logic [8:0] e;
        @(negedge clock);
        cyc++;
        adv = pix_valid && pix_ready;
        if (done) begin
            done_cnt++;
            chk("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 1));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_pix", 64'(out_pix), 64'(e[7:0]));
                chk("out_last", 64'(out_last), 64'(e[8]));
                if (out_last) last_pop_cyc = cyc;
            end
        end
        @(posedge clock);
        #1;
        if (adv) pix_idx++;
        drive_pix();
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic run_row(input int f, input int len, input int stall_at, input int stall_len,
                           input bit mid_start);
        int d0, acc0;
        bit fin;
        acc0 = 0;
        for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), exp_sample(f, k)});
        pix_idx = 0;
        drive_pix();
        d0 = done_cnt;
        frac = 2'(f);
        row_len = 7'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        fin = 1'b0;
        for (int i = 0; i < 600 && !fin; i++) begin
            if (i == stall_at) begin
                stall_cnt = stall_len;
                acc0 = pix_idx;
            end
            if (mid_start && i == 12) begin
                start = 1'b1;
                frac = 2'd2;
                row_len = 7'd5;
            end
            step();
            start = 1'b0;
            if (stall_len > 0 && i == stall_at + 12) begin
                chk("stall_pix_ready", 64'(pix_ready), 64'd0);
                chk("stall_credit", 64'(pix_idx - acc0 <= 3), 64'd1);
            end
            if (done_cnt != d0) fin = 1'b1;
        end
        chk("row_done", 64'(done_cnt - d0), 64'd1);
        chk("row_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        reset_L = 1'b0; start = 1'b0; frac = 2'd0; row_len = 7'd0;
        pix_in = 8'd0; pix_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_pix", 64'(out_pix), 64'd0);
        chk("rst_fir_pixels", fir_pixels, 64'd0);
        reset_L = 1'b1;
        step();
        step();

        // integer bypass on a ramp
        pix_q.delete();
        for (int i = 0; i < 15; i++) pix_q.push_back(8'(i));
        run_row(0, 8, -1, 0, 1'b0);
        chk("t1_accepted", 64'(pix_idx), 64'd15);

        // flat field through each filter
        for (int f = 1; f < 4; f++) begin
            pix_q.delete();
            for (int i = 0; i < 11; i++) pix_q.push_back(8'd100);
            run_row(f, 4, -1, 0, 1'b0);
        end

        // half-pel clamp; two surplus pixels must stay unconsumed
        pix_q.delete();
        for (int i = 0; i < 25; i++) pix_q.push_back((i == 10) ? 8'd0 : 8'd255);
        run_row(2, 16, -1, 0, 1'b0);
        repeat (4) step();
        chk("t3_accepted", 64'(pix_idx), 64'd23);

        // downstream stall mid-row
        pix_q.delete();
        for (int i = 0; i < 39; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        run_row(1, 32, 15, 20, 1'b0);

        // illegal lengths
        row_len = 7'd0; start = 1'b1; step(); start = 1'b0;
        chk("err_len0", 64'(err), 64'd1);
        chk("err_len0_busy", 64'(busy), 64'd0);
        step();
        chk("err_pulse_len0", 64'(err), 64'd0);
        row_len = 7'd65; start = 1'b1; step(); start = 1'b0;
        chk("err_len65", 64'(err), 64'd1);
        chk("err_len65_busy", 64'(busy), 64'd0);

        // start during a row is ignored
        pix_q.delete();
        for (int i = 0; i < 27; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        run_row(3, 20, -1, 0, 1'b1);

        // maximum row length
        pix_q.delete();
        for (int i = 0; i < 71; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        run_row(0, 64, -1, 0, 1'b0);

        // asynchronous reset in the middle of RUN
        pix_q.delete();
        for (int i = 0; i < 39; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        for (int k = 0; k < 32; k++) exp_q.push_back({(k == 31), exp_sample(1, k)});
        pix_idx = 0;
        drive_pix();
        frac = 2'd1; row_len = 7'd32; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_pix_ready", 64'(pix_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_last", 64'(out_last), 64'd0);
        chk("arst_out_pix", 64'(out_pix), 64'd0);
        chk("arst_fir_pixels", fir_pixels, 64'd0);
        exp_q.delete();
        stall_cnt = 0;
        begin
            int d0;
            d0 = done_cnt;
            step();
            step();
            reset_L = 1'b1;
            step();
            chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
        end
        pix_q.delete();
        for (int i = 0; i < 9; i++) pix_q.push_back(8'(10 + i));
        run_row(3, 2, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
